segment_sequencer: RTL and testbench
====================================

# segment_sequencer

Sequences the 64-channel synthesis datapath through a programmed list of segments, each a duration plus a selection of one of several pre-loaded amplitude/offset/phase-word banks. It owns the datapath's reset and run-enable and reports segment and sequence completion, replacing ad-hoc single-segment countdown logic in the top level. It lives entirely in the `clk1` domain. Host-side pipe/trigger endpoints feed its write and control inputs through existing clock-crossing trigger endpoints.

## Interface
- `DEPTH`, 8: segment table entries; power of two, 2..32.
- `TIME_W`, 16: duration field width.
- `SLOT_W`, 2: bank-select width; selects 1 of 2^SLOT_W config banks.
- `clk1` in 1: sole clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `seg_wr` in 1: append `{seg_time, seg_slot}` to table.
- `seg_time` in TIME_W: segment duration, in cycles minus one.
- `seg_slot` in SLOT_W: bank index for the segment.
- `clear` in 1: empty the table.
- `start` in 1: begin the sequence at entry 0.
- `abort` in 1: stop immediately.
- `block_reset` out 1: one-cycle datapath reset at each segment load.
- `block_active` out 1: datapath run-enable.
- `slot_sel` out SLOT_W: bank currently applied.
- `seg_index` out $clog2(DEPTH): entry currently running.
- `time_left` out TIME_W: remaining count.
- `seg_count` out $clog2(DEPTH)+1: entries stored.
- `seg_done` out 1: pulse at end of each segment.
- `finished` out 1: pulse when the sequence completes.
- `busy` out 1: high in LOAD or RUN.
- `wr_err` out 1: pulse when a write is dropped.

## Operation
- States:
  - IDLE: waits; accepts writes.
  - LOAD: one cycle.
    - Latches `slot_sel`/`time_left` from `table[seg_index]`.
    - Asserts `block_reset`.
    - Goes to RUN.
  - RUN: asserts `block_active`.
    - If `time_left != 0`, decrement.
    - If `time_left == 0`:
      - Pulse `seg_done`.
      - If not the last entry (`seg_index != seg_count-1`): increment `seg_index` and go to LOAD.
      - If the last entry: go to DONE.
  - DONE: pulses `finished` on the entry cycle; accepts writes.
- From IDLE or DONE:
  - `start` with `seg_count > 0`: set `seg_index`=0 and go to LOAD.
  - `start` with `seg_count == 0`: ignored; state unchanged.
- `clear`:
  - In IDLE or DONE: zeroes `seg_count`; state becomes IDLE.
  - In LOAD or RUN: ignored.
- Writes:
  - Accepted only in IDLE or DONE, and only while `seg_count < DEPTH`.
  - Otherwise the write is dropped and `wr_err` pulses.
- `abort`: from any state, go to IDLE next cycle with `block_active` 0; the table is retained.
- Priority (same cycle): `abort` > `clear` > `start` > `seg_wr`.
  - `clear` + `seg_wr` in IDLE: write dropped, no `wr_err`.
  - `start` + `seg_wr` in IDLE: write is stored; the start uses `seg_count` sampled before the write.
- Duration: each segment occupies exactly `seg_time`+2 cycles (1 LOAD + `seg_time`+1 RUN). `seg_time`=0 is legal.

## Timing
- All outputs are registered.
- Reset values: all outputs 0; state IDLE; table contents don't-care.
- `start` at edge N: LOAD visible N+1; `block_reset`=1 during N+1; `block_active`=1 from N+2.
- Segment-to-segment gap is one LOAD cycle; `block_active` drops for that cycle.
- `finished` is high for one cycle, one cycle after the final RUN cycle.
- `reset_n` deassertion is synchronized internally (two-flop) before it releases the state register.

## Configuration
- `SEQ_LOOP_EN` defined:
  - In RUN, the last entry's completion returns to LOAD with `seg_index`=0 instead of DONE.
  - `finished` pulses once per pass, coincident with that LOAD.
  - Stops only on `abort`.
- `SEQ_LOOP_EN` undefined: one pass, then DONE as above.

## Structure
- Package `wavegen_pkg`:
  - state enum (IDLE/LOAD/RUN/DONE).
  - segment record `{time, slot}`.
  - default `DEPTH`/`TIME_W`/`SLOT_W` constants.
- Sub-module `seg_table`:
  - DEPTH×(TIME_W+SLOT_W) register file.
  - Write port with append pointer and count.
  - Combinational read by index.

## Test plan
- Write 3 segments (time 4/slot 1, 0/2, 2/3), `start`:
  - `block_reset` pulses at cycles 1, 7, 9; `slot_sel` 1→2→3.
  - `finished` at cycle 13.
  - `seg_done` ×3.
- 8 writes then a 9th with DEPTH=8: 9th dropped, `wr_err` pulse, `seg_count`=8.
- `abort` mid-RUN of segment 2: IDLE next cycle, `block_active`=0, no `finished`, `seg_count` unchanged.
- `start` with empty table: no state change, no outputs. `clear` during RUN: ignored.
- `reset_n` low mid-RUN: all outputs 0 asynchronously; after release, `start` replays correctly.
- `SEQ_LOOP_EN`, 2 segments of time 1: `finished` every 6 cycles for ≥3 passes; `abort` stops.

Source files
------------

// File: rtl/segment_sequencer_pkg.sv
// Shared types and default sizing for the segment sequencer.
// Provides the sequencer state encoding, the segment record layout and
// the default table geometry used by the interface and modules.
package wavegen_pkg;

  localparam int DEF_DEPTH  = 8;
  localparam int DEF_TIME_W = 16;
  localparam int DEF_SLOT_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  // Segment record at the default widths; seg_table stores the same
  // {dur, slot} layout sized by its own parameters.
  typedef struct packed {
    logic [DEF_TIME_W-1:0] dur;
    logic [DEF_SLOT_W-1:0] slot;
  } seg_rec_t;

endpackage

// File: rtl/segment_sequencer_if.sv
// Control/status bundle between the host-side trigger endpoints and the
// segment sequencer. master = host side, slave = sequencer.
interface segment_sequencer_if
  import wavegen_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TIME_W = DEF_TIME_W,
  parameter int SLOT_W = DEF_SLOT_W
);

  localparam int IDX_W = $clog2(DEPTH);

  logic              seg_wr;
  logic [TIME_W-1:0] seg_time;
  logic [SLOT_W-1:0] seg_slot;
  logic              clear;
  logic              start;
  logic              abort;

  logic              block_reset;
  logic              block_active;
  logic [SLOT_W-1:0] slot_sel;
  logic [IDX_W-1:0]  seg_index;
  logic [TIME_W-1:0] time_left;
  logic [IDX_W:0]    seg_count;
  logic              seg_done;
  logic              finished;
  logic              busy;
  logic              wr_err;

  modport master (
    output seg_wr, seg_time, seg_slot, clear, start, abort,
    input  block_reset, block_active, slot_sel, seg_index, time_left,
           seg_count, seg_done, finished, busy, wr_err
  );

  modport slave (
    input  seg_wr, seg_time, seg_slot, clear, start, abort,
    output block_reset, block_active, slot_sel, seg_index, time_left,
           seg_count, seg_done, finished, busy, wr_err
  );

endinterface

// File: rtl/segment_sequencer_seg_table.sv
// Segment table: DEPTH-entry append-only register file with a fill count
// and a combinational read port addressed by segment index.
module seg_table
  import wavegen_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TIME_W = DEF_TIME_W,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic                     clr_i,
  input  logic [TIME_W-1:0]        wr_time_i,
  input  logic [SLOT_W-1:0]        wr_slot_i,
  input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
  output logic [TIME_W-1:0]        rd_time_o,
  output logic [SLOT_W-1:0]        rd_slot_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [TIME_W-1:0] dur;
    logic [SLOT_W-1:0] slot;
  } entry_t;

  entry_t         mem_q [DEPTH];
  logic [IDX_W:0] count_q;
  logic [IDX_W:0] count_d;

  // Append at the current fill level; the caller never writes when full.
  always_ff @(posedge clk1) begin
    if (wr_en_i) begin
      mem_q[count_q[IDX_W-1:0]] <= {wr_time_i, wr_slot_i};
    end
  end

  // Fill count: clear wins over an append in the same cycle.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (wr_en_i) begin
      count_d = count_q + (IDX_W+1)'(1);
    end
  end

  // Fill count register.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign rd_time_o = mem_q[rd_idx_i].dur;
  assign rd_slot_o = mem_q[rd_idx_i].slot;
  assign count_o   = count_q;

endmodule

// File: rtl/segment_sequencer.sv
// Segment sequencer: steps the synthesis datapath through the programmed
// segment table, driving the datapath reset/run-enable and bank select.
// Optional build macro SEQ_LOOP_EN: repeat the table until aborted instead
// of stopping in DONE after one pass.
module segment_sequencer
  import wavegen_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TIME_W = DEF_TIME_W,
  parameter int SLOT_W = DEF_SLOT_W
) (
  input  logic               clk1,
  input  logic               reset_n,
  segment_sequencer_if.slave bus
);

  localparam int             IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] ONE_CNT  = (IDX_W+1)'(1);

  logic [1:0]        rst_sync_q;
  logic              rst_n_int;

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  seg_index_q, seg_index_d;
  logic [SLOT_W-1:0] slot_sel_q, slot_sel_d;
  logic [TIME_W-1:0] time_left_q, time_left_d;
  logic              block_reset_q, block_reset_d;
  logic              block_active_q, block_active_d;
  logic              busy_q, busy_d;
  logic              seg_done_q, seg_done_d;
  logic              finished_q, finished_d;
  logic              wr_err_q, wr_err_d;

  logic              tbl_wr;
  logic              tbl_clr;
  logic [TIME_W-1:0] tbl_time;
  logic [SLOT_W-1:0] tbl_slot;
  logic [IDX_W:0]    seg_count;
  logic              last_seg;

  // Reset asserts immediately but releases only after two clk1 edges.
  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n_int = rst_sync_q[1];

  seg_table #(
    .DEPTH  (DEPTH),
    .TIME_W (TIME_W),
    .SLOT_W (SLOT_W)
  ) u_table (
    .clk1      (clk1),
    .rst_n     (rst_n_int),
    .wr_en_i   (tbl_wr),
    .clr_i     (tbl_clr),
    .wr_time_i (bus.seg_time),
    .wr_slot_i (bus.seg_slot),
    .rd_idx_i  (seg_index_q),
    .rd_time_o (tbl_time),
    .rd_slot_o (tbl_slot),
    .count_o   (seg_count)
  );

  assign last_seg = ({1'b0, seg_index_q} == (seg_count - ONE_CNT));

  // Next state and next values of every registered output.
  always_comb begin
    state_d     = state_q;
    seg_index_d = seg_index_q;
    slot_sel_d  = slot_sel_q;
    time_left_d = time_left_q;
    seg_done_d  = 1'b0;
    finished_d  = 1'b0;
    tbl_wr      = 1'b0;
    tbl_clr     = 1'b0;

    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.clear) begin
            tbl_clr = 1'b1;
            state_d = ST_IDLE;
          end else begin
            // start sees the count from before a same-cycle append
            if (bus.start && (seg_count != '0)) begin
              seg_index_d = '0;
              state_d     = ST_LOAD;
            end
            if (bus.seg_wr && (seg_count < FULL_CNT)) begin
              tbl_wr = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          slot_sel_d  = tbl_slot;
          time_left_d = tbl_time;
          state_d     = ST_RUN;
        end
        ST_RUN: begin
          if (time_left_q != '0) begin
            time_left_d = time_left_q - TIME_W'(1);
          end else begin
            seg_done_d = 1'b1;
            if (!last_seg) begin
              seg_index_d = seg_index_q + IDX_W'(1);
              state_d     = ST_LOAD;
            end else begin
              finished_d = 1'b1;
`ifdef SEQ_LOOP_EN
              seg_index_d = '0;
              state_d     = ST_LOAD;
`else
              state_d     = ST_DONE;
`endif
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A write silently discarded by clear is not an error.
    wr_err_d       = bus.seg_wr && !tbl_wr && !tbl_clr;
    block_reset_d  = (state_d == ST_LOAD);
    block_active_d = (state_d == ST_RUN);
    busy_d         = (state_d == ST_LOAD) || (state_d == ST_RUN);
  end

  // State and output registers.
  always_ff @(posedge clk1 or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q        <= ST_IDLE;
      seg_index_q    <= '0;
      slot_sel_q     <= '0;
      time_left_q    <= '0;
      block_reset_q  <= 1'b0;
      block_active_q <= 1'b0;
      busy_q         <= 1'b0;
      seg_done_q     <= 1'b0;
      finished_q     <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      seg_index_q    <= seg_index_d;
      slot_sel_q     <= slot_sel_d;
      time_left_q    <= time_left_d;
      block_reset_q  <= block_reset_d;
      block_active_q <= block_active_d;
      busy_q         <= busy_d;
      seg_done_q     <= seg_done_d;
      finished_q     <= finished_d;
      wr_err_q       <= wr_err_d;
    end
  end

  assign bus.block_reset  = block_reset_q;
  assign bus.block_active = block_active_q;
  assign bus.slot_sel     = slot_sel_q;
  assign bus.seg_index    = seg_index_q;
  assign bus.time_left    = time_left_q;
  assign bus.seg_count    = seg_count;
  assign bus.seg_done     = seg_done_q;
  assign bus.finished     = finished_q;
  assign bus.busy         = busy_q;
  assign bus.wr_err       = wr_err_q;

endmodule

// File: tb/tb_segment_sequencer.sv
// Directed bench for segment_sequencer (DEPTH=8, TIME_W=16, SLOT_W=2).
// Flags vector order in expectations: {block_reset, block_active, busy,
// seg_done, finished, wr_err}.
module tb_segment_sequencer;

  logic clk1 = 1'b0;
  logic reset_n = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  segment_sequencer_if #(.DEPTH(8), .TIME_W(16), .SLOT_W(2)) bus ();

  segment_sequencer #(.DEPTH(8), .TIME_W(16), .SLOT_W(2)) dut (
    .clk1    (clk1),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [5:0] flags,
                            input logic [1:0] slot, input logic [2:0] idx,
                            input logic [3:0] cnt, input logic [15:0] tl);
    logic [30:0] obs;
    logic [30:0] exp;
    obs = {bus.block_reset, bus.block_active, bus.busy, bus.seg_done,
           bus.finished, bus.wr_err, bus.slot_sel, bus.seg_index,
           bus.seg_count, bus.time_left};
    exp = {flags, slot, idx, cnt, tl};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_seg(input logic [15:0] t, input logic [1:0] s);
    bus.seg_wr   = 1'b1;
    bus.seg_time = t;
    bus.seg_slot = s;
    tick();
    bus.seg_wr   = 1'b0;
  endtask

  initial begin
    bus.seg_wr   = 1'b0;
    bus.seg_time = '0;
    bus.seg_slot = '0;
    bus.clear    = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;

    // Reset state
    repeat (3) tick();
    expect_out("reset", 6'b000000, 2'd0, 3'd0, 4'd0, 16'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    expect_out("post_reset", 6'b000000, 2'd0, 3'd0, 4'd0, 16'd0);

    // Three-segment pass: 4/1, 0/2, 2/3
    write_seg(16'd4, 2'd1);
    write_seg(16'd0, 2'd2);
    write_seg(16'd2, 2'd3);
    expect_out("t1_written", 6'b000000, 2'd0, 3'd0, 4'd3, 16'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("t1_c1_load", 6'b101000, 2'd0, 3'd0, 4'd3, 16'd0);
    for (int t = 4; t >= 0; t--) begin
      tick();
      expect_out("t1_run0", 6'b011000, 2'd1, 3'd0, 4'd3, 16'(t));
    end
    tick();
    expect_out("t1_c7_load", 6'b101100, 2'd1, 3'd1, 4'd3, 16'd0);
    tick();
    expect_out("t1_c8_run1", 6'b011000, 2'd2, 3'd1, 4'd3, 16'd0);
    tick();
    expect_out("t1_c9_load", 6'b101100, 2'd2, 3'd2, 4'd3, 16'd0);
    for (int t = 2; t >= 0; t--) begin
      tick();
      expect_out("t1_run2", 6'b011000, 2'd3, 3'd2, 4'd3, 16'(t));
    end
`ifdef SEQ_LOOP_EN
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    expect_out("t1_abort_end", 6'b000000, 2'd3, 3'd2, 4'd3, 16'd0);
`else
    tick();
    expect_out("t1_c13_done", 6'b000110, 2'd3, 3'd2, 4'd3, 16'd0);
    tick();
    expect_out("t1_c14_quiet", 6'b000000, 2'd3, 3'd2, 4'd3, 16'd0);
`endif

    // clear empties the table; start on an empty table is ignored
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    expect_out("t2_clear", 6'b000000, 2'd3, 3'd2, 4'd0, 16'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("t2_start_empty", 6'b000000, 2'd3, 3'd2, 4'd0, 16'd0);
    tick();
    expect_out("t2_still_idle", 6'b000000, 2'd3, 3'd2, 4'd0, 16'd0);

    // Fill to DEPTH, then one write too many
    for (int i = 0; i < 8; i++) write_seg(16'(i), 2'(i));
    expect_out("t3_full", 6'b000000, 2'd3, 3'd2, 4'd8, 16'd0);
    write_seg(16'd7, 2'd1);
    expect_out("t3_overflow", 6'b000001, 2'd3, 3'd2, 4'd8, 16'd0);
    tick();
    expect_out("t3_err_pulse", 6'b000000, 2'd3, 3'd2, 4'd8, 16'd0);

    // clear + write: write dropped without error
    bus.clear = 1'b1;
    write_seg(16'd5, 2'd1);
    bus.clear = 1'b0;
    expect_out("t4_clear_wr", 6'b000000, 2'd3, 3'd2, 4'd0, 16'd0);

    // start + write on empty table: write kept, start ignored
    bus.start = 1'b1;
    write_seg(16'd3, 2'd2);
    bus.start = 1'b0;
    expect_out("t5_start_wr_empty", 6'b000000, 2'd3, 3'd2, 4'd1, 16'd0);
    // start + write with one entry: sequence starts, write stored
    bus.start = 1'b1;
    write_seg(16'd5, 2'd1);
    bus.start = 1'b0;
    expect_out("t5_c1_load", 6'b101000, 2'd3, 3'd0, 4'd2, 16'd0);
    for (int t = 3; t >= 0; t--) begin
      tick();
      expect_out("t5_run0", 6'b011000, 2'd2, 3'd0, 4'd2, 16'(t));
    end
    tick();
    expect_out("t5_c6_load", 6'b101100, 2'd2, 3'd1, 4'd2, 16'd0);
    tick();
    expect_out("t5_c7_run1", 6'b011000, 2'd1, 3'd1, 4'd2, 16'd5);
    // clear ignored during RUN; the write is dropped with an error
    bus.clear = 1'b1;
    write_seg(16'd9, 2'd0);
    bus.clear = 1'b0;
    expect_out("t5_clear_in_run", 6'b011001, 2'd1, 3'd1, 4'd2, 16'd4);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    expect_out("t5_abort", 6'b000000, 2'd1, 3'd1, 4'd2, 16'd4);
    tick();
    expect_out("t5_after_abort", 6'b000000, 2'd1, 3'd1, 4'd2, 16'd4);

    // Asynchronous reset mid-RUN
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("t6_c1_load", 6'b101000, 2'd1, 3'd0, 4'd2, 16'd4);
    tick();
    expect_out("t6_c2_run", 6'b011000, 2'd2, 3'd0, 4'd2, 16'd3);
    reset_n = 1'b0;
    #1;
    expect_out("t6_async_reset", 6'b000000, 2'd0, 3'd0, 4'd0, 16'd0);
    repeat (2) tick();
    expect_out("t6_held_reset", 6'b000000, 2'd0, 3'd0, 4'd0, 16'd0);
    reset_n = 1'b1;
    repeat (3) tick();
    expect_out("t6_released", 6'b000000, 2'd0, 3'd0, 4'd0, 16'd0);
    write_seg(16'd0, 2'd3);
    write_seg(16'd1, 2'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    expect_out("t6_r1_load", 6'b101000, 2'd0, 3'd0, 4'd2, 16'd0);
    tick();
    expect_out("t6_r2_run", 6'b011000, 2'd3, 3'd0, 4'd2, 16'd0);
    tick();
    expect_out("t6_r3_load", 6'b101100, 2'd3, 3'd1, 4'd2, 16'd0);
    tick();
    expect_out("t6_r4_run", 6'b011000, 2'd2, 3'd1, 4'd2, 16'd1);
    tick();
    expect_out("t6_r5_run", 6'b011000, 2'd2, 3'd1, 4'd2, 16'd0);
`ifdef SEQ_LOOP_EN
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    expect_out("t6_abort_end", 6'b000000, 2'd2, 3'd1, 4'd2, 16'd0);

    // Looping: two segments of time 1, finished every 6 cycles
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    write_seg(16'd1, 2'd1);
    write_seg(16'd1, 2'd2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      chk1("t7_finished", 32'(bus.finished), 32'((c > 1) && (c % 6 == 1)));
      chk1("t7_block_reset", 32'(bus.block_reset), 32'(c % 3 == 1));
      if (c < 20) tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    expect_out("t7_abort", 6'b000000, 2'd1, 3'd0, 4'd2, 16'd1);
    for (int c = 0; c < 6; c++) begin
      tick();
      chk1("t7_stopped", 32'({bus.finished, bus.busy}), 32'd0);
    end
`else
    tick();
    expect_out("t6_r6_done", 6'b000110, 2'd2, 3'd1, 4'd2, 16'd0);
    tick();
    expect_out("t6_r7_quiet", 6'b000000, 2'd2, 3'd1, 4'd2, 16'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
